// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared types and helpers for the NN classifier output path:
//               binary32 field layout, argmax FSM states and a NaN test.
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

  localparam int         FP32_W       = 32;
  localparam logic [7:0] FP32_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [0:0] {
    ST_ACCUM  = 1'b0,
    ST_RESULT = 1'b1
  } argmax_state_t;

  // A value is NaN when the exponent is saturated and the mantissa is non-zero
  function automatic logic fp32_is_nan(input fp32_t x);
    return (x.exp == FP32_EXP_MAX) && (x.mant != 23'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fp32_gt.sv
`default_nettype none
// ============================================================================
// Module      : fp32_gt
// Description : Combinational strict greater-than for IEEE-754 binary32.
//               NaN ranks below every number, +0 equals -0.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_gt
  import nn_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic              a_gt_b
);

  fp32_t w_a;
  fp32_t w_b;
  logic  w_a_nan;
  logic  w_b_nan;
  logic  w_both_zero;

  assign w_a         = fp32_t'(a);
  assign w_b         = fp32_t'(b);
  assign w_a_nan     = fp32_is_nan(w_a);
  assign w_b_nan     = fp32_is_nan(w_b);
  assign w_both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);

  // Sign-magnitude ordering with NaN pinned below everything
  always_comb begin
    a_gt_b = 1'b0;
    if (w_a_nan) begin
      a_gt_b = 1'b0;
    end else if (w_b_nan) begin
      a_gt_b = 1'b1;
    end else if (w_both_zero) begin
      a_gt_b = 1'b0;
    end else if (w_a.sign != w_b.sign) begin
      a_gt_b = !w_a.sign;
    end else if (!w_a.sign) begin
      a_gt_b = (a[30:0] > b[30:0]);
    end else begin
      a_gt_b = (a[30:0] < b[30:0]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_argmax.sv
`default_nettype none
// ============================================================================
// Module      : stream_argmax
// Description : Streaming top-1/top-2 tracker over one frame of binary32
//               class scores; result held until the consumer takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_argmax
  import nn_pkg::*;
#(
  parameter int N_CLASSES = 10,
  parameter int IDX_W     = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_score,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_score,
  output logic [IDX_W-1:0]  out_second_index,
  output logic              out_nan,
  output logic              out_len_err
);

  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(N_CLASSES - 1);

  argmax_state_t     r_state;
  argmax_state_t     w_state_next;
  logic [IDX_W-1:0]  r_count;
  logic [DATA_W-1:0] r_top_score, w_top_score;
  logic [IDX_W-1:0]  r_top_idx,   w_top_idx;
  logic [DATA_W-1:0] r_sec_score, w_sec_score;
  logic [IDX_W-1:0]  r_sec_idx,   w_sec_idx;
  logic              r_sec_empty, w_sec_empty;
  logic              r_nan,       w_nan;
  logic              w_xfer;
  logic              w_first;
  logic              w_at_last;
  logic              w_close;
  logic              w_in_nan;
  logic              w_gt_top;
  logic              w_gt_sec;

  assign in_ready  = (r_state == ST_ACCUM) && !reset;
  assign out_valid = (r_state == ST_RESULT);
  assign w_xfer    = in_valid && in_ready;
  assign w_first   = (r_count == '0);
  assign w_at_last = (r_count == C_LAST_IDX);
  assign w_close   = w_xfer && (in_last || w_at_last);
  assign w_in_nan  = fp32_is_nan(fp32_t'(in_score));

  fp32_gt u_gt_top (
    .a      (in_score),
    .b      (r_top_score),
    .a_gt_b (w_gt_top)
  );

  fp32_gt u_gt_sec (
    .a      (in_score),
    .b      (r_sec_score),
    .a_gt_b (w_gt_sec)
  );

  // Next top/second trackers after folding in the incoming score
  always_comb begin
    w_top_score = r_top_score;
    w_top_idx   = r_top_idx;
    w_sec_score = r_sec_score;
    w_sec_idx   = r_sec_idx;
    w_sec_empty = r_sec_empty;
    w_nan       = r_nan;
    if (w_xfer) begin
      if (w_first) begin
        w_top_score = in_score;
        w_top_idx   = '0;
        w_sec_empty = 1'b1;
        w_nan       = w_in_nan;
      end else begin
        w_nan = r_nan | w_in_nan;
        if (w_gt_top) begin
          // Old leader is demoted; it beats everything the second slot held
          w_sec_score = r_top_score;
          w_sec_idx   = r_top_idx;
          w_sec_empty = 1'b0;
          w_top_score = in_score;
          w_top_idx   = r_count;
        end else if (r_sec_empty || w_gt_sec) begin
          w_sec_score = in_score;
          w_sec_idx   = r_count;
          w_sec_empty = 1'b0;
        end
      end
    end
  end

  // Frame accumulation vs. result hold
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ACCUM:  if (w_close)   w_state_next = ST_RESULT;
      ST_RESULT: if (out_ready) w_state_next = ST_ACCUM;
      default:                  w_state_next = ST_ACCUM;
    endcase
  end

  // State, counter, trackers and the held result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_ACCUM;
      r_count          <= '0;
      r_top_score      <= '0;
      r_top_idx        <= '0;
      r_sec_score      <= '0;
      r_sec_idx        <= '0;
      r_sec_empty      <= 1'b1;
      r_nan            <= 1'b0;
      out_index        <= '0;
      out_score        <= '0;
      out_second_index <= '0;
      out_nan          <= 1'b0;
      out_len_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_xfer) begin
        r_top_score <= w_top_score;
        r_top_idx   <= w_top_idx;
        r_sec_score <= w_sec_score;
        r_sec_idx   <= w_sec_idx;
        r_sec_empty <= w_sec_empty;
        r_nan       <= w_nan;
        r_count     <= w_close ? '0 : r_count + 1'b1;
      end
      if (w_close) begin
        out_index        <= w_top_idx;
        out_score        <= w_top_score;
        // A lone element is its own runner-up
        out_second_index <= w_sec_empty ? w_top_idx : w_sec_idx;
        out_nan          <= w_nan;
        out_len_err      <= !(in_last && w_at_last);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_argmax.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_argmax
// Description : Self-checking bench for stream_argmax: directed frames with
//               literal expectations plus random frames against an
//               order-key reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_argmax;

  localparam int N  = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_score;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic [31:0]   out_score;
  logic [IW-1:0] out_second_index;
  logic          out_nan;
  logic          out_len_err;

  stream_argmax #(.N_CLASSES(N), .IDX_W(IW), .DATA_W(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_score         (in_score),
    .in_last          (in_last),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_index        (out_index),
    .out_score        (out_score),
    .out_second_index (out_second_index),
    .out_nan          (out_nan),
    .out_len_err      (out_len_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] frame_q[$];
  bit          pending = 1'b0;
  bit          live    = 1'b0;
  int          e_idx, e_sec;
  logic [31:0] e_score;
  bit          e_nan, e_len;
  logic [31:0] d_idx, d_sec, d_score, d_nan, d_len;
  bit          hold_ready = 1'b0;
  bit          gaps = 1'b0;
  logic [31:0] stim [N];

  // Total order: NaN at the bottom, then signed magnitude (+0 == -0)
  function automatic longint fkey(input logic [31:0] x);
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return -(longint'(1) << 40);
    if (x[31]) return -longint'(x[30:0]);
    return longint'(x[30:0]);
  endfunction

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  task automatic model_close(input bit last);
    int top, sec, len;
    len = frame_q.size();
    top = 0;
    sec = -1;
    e_nan = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (fkey(frame_q[i]) > fkey(frame_q[top])) top = i;
      if (is_nan(frame_q[i])) e_nan = 1'b1;
    end
    for (int i = 0; i < len; i++)
      if (i != top && (sec < 0 || fkey(frame_q[i]) > fkey(frame_q[sec]))) sec = i;
    if (sec < 0) sec = top;
    e_idx   = top;
    e_sec   = sec;
    e_score = frame_q[top];
    e_len   = !(last && len == N);
  endtask

  // Compare on every cycle, then apply the handshake events due at the next edge
  always @(negedge clk) begin
    if (live) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!pending && !reset)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, pending});
      if (pending) begin
        chk("out_index", {28'd0, out_index}, e_idx);
        chk("out_second_index", {28'd0, out_second_index}, e_sec);
        chk("out_score", out_score, e_score);
        chk("out_nan", {31'd0, out_nan}, {31'd0, e_nan});
        chk("out_len_err", {31'd0, out_len_err}, {31'd0, e_len});
      end
    end
    if (reset) begin
      frame_q.delete();
      pending = 1'b0;
      live    = 1'b1;
    end else if (pending) begin
      if (out_ready) begin
        d_idx   = {28'd0, out_index};
        d_sec   = {28'd0, out_second_index};
        d_score = out_score;
        d_nan   = {31'd0, out_nan};
        d_len   = {31'd0, out_len_err};
        pending = 1'b0;
      end
    end else if (in_valid) begin
      frame_q.push_back(in_score);
      if (in_last || frame_q.size() == N) begin
        model_close(in_last);
        pending = 1'b1;
        frame_q.delete();
      end
    end
  end

  // Consumer: random acceptance unless held off
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int len, input bit last_flag);
    bit acc;
    int guard;
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_score = stim[i];
      in_last  = (i == len - 1) && last_flag;
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        guard++;
        if (!acc && guard > 200) begin
          n_cmp++;
          n_bad++;
          $display("FAIL send_timeout: got in_ready=0 expected acceptance within 200 cycles");
          acc = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (pending && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (pending) begin
      n_cmp++;
      n_bad++;
      $display("FAIL result_timeout: got out_valid held expected acceptance within 200 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rnd_score();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0, 1: return r;
      2: case (r[3:0])
           4'd0: return 32'h3F800000;
           4'd1: return 32'h40000000;
           4'd2: return 32'hBF800000;
           4'd3: return 32'hC0000000;
           4'd4: return 32'h00000000;
           4'd5: return 32'h80000000;
           4'd6: return 32'h7F800000;
           4'd7: return 32'hFF800000;
           4'd8: return 32'h00000001;
           4'd9: return 32'h80000001;
           default: return 32'h3F800000;
         endcase
      3: return {r[31], 8'hFF, 22'd0, 1'b1} | {9'd0, r[22:0]};
      4: return {r[31], 8'h7F, 21'd0, r[1:0]};
      default: return {r[31], 8'($urandom_range(120, 135)), r[22:0]};
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_score = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_index", {28'd0, out_index}, 32'd0);
    chk("reset_out_second", {28'd0, out_second_index}, 32'd0);
    chk("reset_out_score", out_score, 32'd0);
    chk("reset_flags", {30'd0, out_nan, out_len_err}, 32'd0);
    @(posedge clk); #1;

    // 1.0 .. 10.0 ascending
    for (int i = 0; i < N; i++) stim[i] = 32'h3F800000;
    stim[1] = 32'h40000000; stim[2] = 32'h40400000; stim[3] = 32'h40800000;
    stim[4] = 32'h40A00000; stim[5] = 32'h40C00000; stim[6] = 32'h40E00000;
    stim[7] = 32'h41000000; stim[8] = 32'h41100000; stim[9] = 32'h41200000;
    send(N, 1'b1);
    wait_idle();
    chk("asc_index", d_idx, 32'd9);
    chk("asc_second", d_sec, 32'd8);
    chk("asc_score", d_score, 32'h41200000);
    chk("asc_len_err", d_len, 32'd0);

    // All negative
    for (int i = 0; i < N; i++) stim[i] = (i % 2) ? 32'hC0C00000 : 32'hC0E00000;
    stim[3] = 32'hC0A00000;
    stim[7] = 32'hBF000000;
    send(N, 1'b1);
    wait_idle();
    chk("neg_index", d_idx, 32'd7);
    chk("neg_second", d_sec, 32'd3);
    chk("neg_score", d_score, 32'hBF000000);

    // Ties and signed zero
    for (int i = 0; i < N; i++) stim[i] = 32'h00000000;
    stim[0] = 32'h80000000;
    stim[2] = 32'h40000000;
    stim[6] = 32'h40000000;
    send(N, 1'b1);
    wait_idle();
    chk("tie_index", d_idx, 32'd2);
    chk("tie_second", d_sec, 32'd6);

    // NaN in frame
    for (int i = 0; i < N; i++) stim[i] = 32'h00000000;
    stim[4] = 32'h7FC00000;
    stim[1] = 32'h3F800000;
    send(N, 1'b1);
    wait_idle();
    chk("nan_index", d_idx, 32'd1);
    chk("nan_flag", d_nan, 32'd1);
    chk("nan_second", d_sec, 32'd0);

    // Short frame, then a normal one
    for (int i = 0; i < N; i++) stim[i] = 32'h3F800000 + 32'(i << 20);
    send(6, 1'b1);
    wait_idle();
    chk("short_len_err", d_len, 32'd1);
    chk("short_index", d_idx, 32'd5);
    send(N, 1'b1);
    wait_idle();
    chk("full_len_err", d_len, 32'd0);
    chk("full_index", d_idx, 32'd9);

    // Backpressure: result held while producer keeps offering data
    hold_ready = 1'b1;
    @(posedge clk); #1;
    send(N, 1'b1);
    in_valid = 1'b1;
    in_score = 32'h7F000000;
    repeat (5) @(posedge clk);
    #1;
    in_valid   = 1'b0;
    hold_ready = 1'b0;
    wait_idle();
    chk("bp_index", d_idx, 32'd9);

    // Reset mid-frame at index 4
    for (int i = 0; i < N; i++) stim[i] = 32'h42000000;
    send(4, 1'b0);
    do_reset();
    for (int i = 0; i < N; i++) stim[i] = 32'h3F800000;
    stim[0] = 32'h40400000;
    stim[5] = 32'h40000000;
    send(N, 1'b1);
    wait_idle();
    chk("rst_index", d_idx, 32'd0);
    chk("rst_second", d_sec, 32'd5);
    chk("rst_score", d_score, 32'h40400000);

    // Random frames
    gaps = 1'b1;
    for (int f = 0; f < 300; f++) begin
      int len;
      bit lf;
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N) : N;
      lf  = (len < N) ? 1'b1 : ($urandom_range(0, 4) != 0);
      for (int i = 0; i < N; i++) stim[i] = rnd_score();
      send(len, lf);
      if ($urandom_range(0, 2) == 0) wait_idle();
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/stream_argmax.md
Name: stream_argmax

Overview:
- Streaming, parametrised argmax for the NN classifier output layer.
- Accepts one IEEE-754 single-precision score per cycle over a valid/ready handshake and tracks the running top-1 and top-2 scores with a correct signed float compare.
- Presents the winning class index, its score and the runner-up index through an output valid/ready handshake.
- Sits between the final dense layer and the display/readout logic.

Parameters:
- N_CLASSES, 10, scores per frame (>=1).
- IDX_W, $clog2(N_CLASSES) (min 1), width of index outputs.
- DATA_W, 32, score width; fixed IEEE-754 binary32 layout: sign [31], exponent [30:23], mantissa [22:0].

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_score is valid.
- in_ready  out  1  block accepts a score this cycle.
- in_score  in  DATA_W  class score, class index = arrival order within the frame.
- in_last  in  1  marks the final score of a frame.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes the result.
- out_index  out  IDX_W  index of the maximum score.
- out_score  out  DATA_W  the maximum score.
- out_second_index  out  IDX_W  index of the second-largest score.
- out_nan  out  1  at least one NaN was seen in the frame.
- out_len_err  out  1  frame length was not N_CLASSES.

Behaviour:
- Reset values: in_ready=0 during the Reset cycle, then 1. out_valid=0; out_index, out_second_index, out_score, out_nan and out_len_err all 0. Element counter 0. FSM in ACCUM.
- FSM ACCUM:
  - in_ready=1. A transfer occurs when in_valid && in_ready.
  - First element of a frame (count==0) loads top=(score,0), marks the second slot empty, and sets the nan flag if that element is NaN.
  - Later elements, index i=count:
    - if gt(s, top): second<=top, top<=(s,i);
    - else if the second slot is empty or gt(s, second): second<=(s,i).
  - Frame closes on the transfer with in_last=1, or on the transfer of element N_CLASSES-1, whichever comes first.
  - On close: go to RESULT. len_err = !(in_last && count==N_CLASSES-1). Counter returns to 0.
- FSM RESULT:
  - in_ready=0, out_valid=1, outputs stable.
  - On out_ready, go to ACCUM on the next cycle.
  - Minimum throughput is one frame per N_CLASSES+1 cycles.
- Latency: out_valid rises on the cycle after the closing transfer.
- Compare gt(a,b), strict greater-than:
  - NaN (exp=255, mantissa!=0) is less than every non-NaN value; NaN vs NaN returns false.
  - +0 and -0 are equal.
  - Signs differ: the non-negative value is greater.
  - Both non-negative: unsigned compare of [30:0].
  - Both negative: a greater when a[30:0] < b[30:0].
  - Denormals and infinities need no special case.
- Ties: the lowest index wins, for both top and second (strict gt only).
- Single-element frame: out_second_index = out_index.
- All-NaN frame: out_index=0 and out_nan=1. out_score is the first NaN pattern.
- Reset mid-frame or in RESULT discards all state, with no output pulse.
- in_valid while in RESULT: no transfer, and input data is ignored.

Decomposition:
- Shared package nn_pkg, holding:
  - typedef fp32_t (packed struct: sign, exp[7:0], mant[22:0]);
  - constants FP32_EXP_MAX=8'hFF and FP32_W=32;
  - function fp32_is_nan.
- Sub-module fp32_gt: purely combinational, inputs a and b, output a_gt_b, implementing the compare above. It is instantiated twice, for top and for second.
- The FSM, counter and trackers stay in stream_argmax.

Test Plan:
- Positive scores 1.0..10.0 (0x3F800000..0x41200000) at indices 0..9, in_last on index 9 -> out_index=9, out_second_index=8, out_score=0x41200000, len_err=0, out_valid one cycle after the last transfer.
- All scores negative, -5.0 at index 3 and -0.5 at index 7 (0xBF000000), others <= -6.0 -> out_index=7, out_second_index=3.
- Equal scores 2.0 at indices 2 and 6, others 0.0, plus -0.0 at index 0 -> out_index=2, out_second_index=6.
- NaN 0x7FC00000 at index 4, 1.0 at index 1, others 0.0 -> out_index=1, out_nan=1.
- in_last asserted on index 5 -> frame closes, len_err=1. The next frame of 10 closes normally with len_err=0.
- Backpressure: hold out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, outputs stable, no input consumed. Separately, assert Reset mid-frame at index 4 -> out_valid stays 0, and the next full frame gives the correct result from index 0.
